// File: rtl/nw_seq_fetch_ctrl.sv
// Fetch sequencer for the two sequence RAMs: walks the fill matrix in row-major order,
// hands character pairs to the scoring PE, then serves single-pair traceback reads.
module nw_seq_fetch_ctrl #(
  parameter int N   = 128,
  parameter int Bit = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [Bit:0]   len_a,
  input  logic [Bit:0]   len_b,
  output logic           en_rd_a,
  output logic [Bit-1:0] addr_a,
  input  logic [8:0]     dout_a,
  output logic           en_rd_b,
  output logic [Bit-1:0] addr_b,
  input  logic [8:0]     dout_b,
  output logic [8:0]     char_a,
  output logic [8:0]     char_b,
  output logic [Bit-1:0] idx_i,
  output logic [Bit-1:0] idx_j,
  output logic           pair_valid,
  input  logic           pair_ready,
  input  logic           trace_req,
  input  logic [Bit-1:0] trace_addr_a,
  input  logic [Bit-1:0] trace_addr_b,
  output logic           trace_gnt,
  output logic           trace_valid,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    IDLE, F_RD, F_WAIT, F_VAL, DONE, T_RD, T_WAIT, T_VAL
  } state_t;

  localparam logic [Bit:0] NMAX = (Bit+1)'(N);

  state_t         state, state_nxt;
  logic [Bit:0]   len_a_q, len_b_q;
  logic [Bit:0]   len_a_m1, len_b_m1;
  logic [Bit-1:0] i_q, j_q, i_nxt, j_nxt;
  logic           start_acc, last_col, last_cell;

  function automatic logic [Bit:0] clamp_len(input logic [Bit:0] l);
    return (l > NMAX) ? NMAX : l;
  endfunction

  assign start_acc = ((state == IDLE) || (state == DONE)) && start;
  assign len_a_m1  = len_a_q - 1'b1;
  assign len_b_m1  = len_b_q - 1'b1;
  assign last_col  = (j_q == len_b_m1[Bit-1:0]);
  assign last_cell = last_col && (i_q == len_a_m1[Bit-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          i_nxt = '0;
          j_nxt = '0;
          if ((clamp_len(len_a) == '0) || (clamp_len(len_b) == '0)) state_nxt = DONE;
          else                                                       state_nxt = F_RD;
        end else if ((state == DONE) && trace_req) begin
          state_nxt = T_RD;
        end
      end
      F_RD:   state_nxt = F_WAIT;
      F_WAIT: state_nxt = F_VAL;
      F_VAL: begin
        if (pair_ready) begin
          if (last_col) begin
            j_nxt = '0;
            i_nxt = i_q + 1'b1;
          end else begin
            j_nxt = j_q + 1'b1;
          end
          state_nxt = last_cell ? DONE : F_RD;
        end
      end
      T_RD:    state_nxt = T_WAIT;
      T_WAIT:  state_nxt = T_VAL;
      T_VAL:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    en_rd_a     = (state == F_RD) || (state == T_RD);
    en_rd_b     = en_rd_a;
    pair_valid  = (state == F_VAL);
    trace_valid = (state == T_VAL);
    done        = (state == DONE);
    busy        = (state != IDLE) && (state != DONE);
    // A start in the same DONE cycle takes precedence over a traceback request
    trace_gnt   = (state == DONE) && trace_req && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_a_q <= '0;
      len_b_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      char_a  <= '0;
      char_b  <= '0;
      idx_i   <= '0;
      idx_j   <= '0;
    end else begin
      i_q <= i_nxt;
      j_q <= j_nxt;
      if (start_acc) begin
        len_a_q <= clamp_len(len_a);
        len_b_q <= clamp_len(len_b);
      end
      // Addresses are loaded one cycle ahead so they are stable during the read cycle
      if (state_nxt == F_RD) begin
        addr_a <= i_nxt;
        addr_b <= j_nxt;
      end else if (trace_gnt) begin
        addr_a <= trace_addr_a;
        addr_b <= trace_addr_b;
      end
      if (state == F_WAIT) begin
        char_a <= dout_a;
        char_b <= dout_b;
        idx_i  <= i_q;
        idx_j  <= j_q;
      end else if (state == T_WAIT) begin
        char_a <= dout_a;
        char_b <= dout_b;
        idx_i  <= addr_a;
        idx_j  <= addr_b;
      end
    end
  end

endmodule

// File: tb/tb_nw_seq_fetch_ctrl.sv
// Directed and randomized checks of nw_seq_fetch_ctrl against a row-major cell-walk model
// with behavioural RAMs holding the two sequences.
module tb_nw_seq_fetch_ctrl;

  localparam int N  = 5;
  localparam int BW = $clog2(N);

  logic          clk, rst_n, start;
  logic [BW:0]   len_a, len_b;
  logic          en_rd_a, en_rd_b;
  logic [BW-1:0] addr_a, addr_b;
  logic [8:0]    dout_a, dout_b;
  logic [8:0]    char_a, char_b;
  logic [BW-1:0] idx_i, idx_j;
  logic          pair_valid, pair_ready;
  logic          trace_req;
  logic [BW-1:0] trace_addr_a, trace_addr_b;
  logic          trace_gnt, trace_valid, busy, done;

  logic [8:0] mem_a [0:7];
  logic [8:0] mem_b [0:7];
  int rd_cnt;
  int cyc;
  int t0;
  int n_cmp;
  int n_err;

  nw_seq_fetch_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_a(len_a), .len_b(len_b),
    .en_rd_a(en_rd_a), .addr_a(addr_a), .dout_a(dout_a),
    .en_rd_b(en_rd_b), .addr_b(addr_b), .dout_b(dout_b),
    .char_a(char_a), .char_b(char_b), .idx_i(idx_i), .idx_j(idx_j),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .trace_req(trace_req), .trace_addr_a(trace_addr_a), .trace_addr_b(trace_addr_b),
    .trace_gnt(trace_gnt), .trace_valid(trace_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAMs with one cycle of latency
  always @(posedge clk) begin
    if (en_rd_a) dout_a <= mem_a[addr_a];
    if (en_rd_b) dout_b <= mem_b[addr_b];
    if (en_rd_a || en_rd_b) rd_cnt <= rd_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out"},
          {23'd0, pair_valid, en_rd_a, en_rd_b, trace_gnt, trace_valid, busy, done, 3'd0}, 32'd0);
    check({tag, "_addr"}, {addr_a, addr_b, idx_i, idx_j}, 32'd0);
    check({tag, "_char"}, {char_a, char_b}, 32'd0);
  endtask

  function automatic int clampl(input int l);
    return (l > N) ? N : l;
  endfunction

  task automatic start_fill(input int la, input int lb);
    len_a = (BW+1)'(la);
    len_b = (BW+1)'(lb);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  // Waits for the expected pair, checks it, optionally stalls, then accepts it
  task automatic take_pair(input int ei, input int ej, input int stall, output int w);
    int rd0;
    w = 0;
    while (pair_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check($sformatf("pv(%0d,%0d)", ei, ej), pair_valid, 1);
    check($sformatf("char_a(%0d,%0d)", ei, ej), char_a, mem_a[ei]);
    check($sformatf("char_b(%0d,%0d)", ei, ej), char_b, mem_b[ej]);
    check($sformatf("idx(%0d,%0d)", ei, ej), {idx_i, idx_j}, {BW'(ei), BW'(ej)});
    check("fill_gnt", trace_gnt, 0);
    check("fill_busy", busy, 1);
    if (stall > 0) begin
      pair_ready = 1'b0;
      rd0 = rd_cnt;
      repeat (stall) begin
        tick();
        check("stall_pv", pair_valid, 1);
        check("stall_chars", {char_a, char_b}, {mem_a[ei], mem_b[ej]});
      end
      check("stall_rd", rd_cnt, rd0);
      pair_ready = 1'b1;
    end
    tick();
  endtask

  task automatic trace_seq(input int ta, input int tb);
    trace_addr_a = BW'(ta);
    trace_addr_b = BW'(tb);
    trace_req = 1'b1;
    #1;
    check("tr_gnt", trace_gnt, 1);
    tick();
    trace_req = 1'b0;
    check("tr_gnt_pulse", trace_gnt, 0);
    check("tr_rd", {en_rd_a, en_rd_b, addr_a, addr_b}, {2'b11, BW'(ta), BW'(tb)});
    tick();
    check("tr_tv_early", trace_valid, 0);
    tick();
    check("tr_tv", trace_valid, 1);
    check("tr_chars", {char_a, char_b}, {mem_a[ta], mem_b[tb]});
    check("tr_idx", {idx_i, idx_j}, {BW'(ta), BW'(tb)});
    tick();
    check("tr_tv_end", {trace_valid, done}, 2'b01);
  endtask

  initial begin
    int w, la, lb, ela, elb, st, stall_tot;
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; len_a = '0; len_b = '0; pair_ready = 1'b1;
    trace_req = 1'b0; trace_addr_a = '0; trace_addr_b = '0;
    for (int k = 0; k < 8; k++) begin
      mem_a[k] = 9'h000;
      mem_b[k] = 9'h000;
    end
    mem_a[0] = 9'h047; mem_a[1] = 9'h041; mem_a[2] = 9'h054; mem_a[3] = 9'h054; mem_a[4] = 9'h043;
    mem_b[0] = 9'h043; mem_b[1] = 9'h054; mem_b[2] = 9'h047; mem_b[3] = 9'h041; mem_b[4] = 9'h054;

    repeat (2) tick();
    check_reset("rst0");
    rst_n = 1'b1;
    tick();

    // Full 5x5 fill with the PE always ready
    start_fill(5, 5);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        take_pair(i, j, 0, w);
        check($sformatf("cadence(%0d,%0d)", i, j), w, 2);
      end
    check("t1_done", {done, busy}, 2'b10);
    check("t1_done_cyc", cyc - t0, 75);

    // Backpressure on (0,1), plus a start pulse mid-fill that must be ignored
    start_fill(5, 5);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        if (i == 1 && j == 1) begin
          len_a = '0;
          start = 1'b1;
        end
        take_pair(i, j, (i == 0 && j == 1) ? 4 : 0, w);
        start = 1'b0;
      end
    check("t2_done_cyc", cyc - t0, 79);

    // Traceback request held during the fill is only granted in DONE
    start_fill(5, 5);
    trace_addr_a = 3'd2;
    trace_addr_b = 3'd4;
    trace_req = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) take_pair(i, j, 0, w);
    check("t3_done", done, 1);
    trace_seq(2, 4);

    // Zero length finishes immediately with no pairs
    start_fill(5, 0);
    check("t4_zero", {done, busy, pair_valid}, 3'b100);
    repeat (3) tick();
    check("t4_zero_hold", {done, pair_valid, en_rd_a}, 3'b100);

    // Oversized length is clamped to N
    start_fill(7, 2);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 2; j++) take_pair(i, j, 0, w);
    check("t4_clamp_done", done, 1);
    check("t4_clamp_cyc", cyc - t0, 30);

    // Start and trace request together in DONE: the fill wins
    len_a = 4'd5; len_b = 4'd5;
    trace_addr_a = 3'd1; trace_addr_b = 3'd1;
    start = 1'b1; trace_req = 1'b1;
    #1;
    check("t4_both_gnt", trace_gnt, 0);
    tick();
    start = 1'b0; trace_req = 1'b0;
    check("t4_both_state", {busy, done, trace_gnt}, 3'b100);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 5; j++)
        if (i < 2 || j < 2) take_pair(i, j, 0, w);
    w = 0;
    while (pair_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("t5_at22", {pair_valid, idx_i, idx_j}, {1'b1, 3'd2, 3'd2});

    // Asynchronous reset in the middle of a presented pair
    rst_n = 1'b0;
    #1;
    check_reset("t5_rst");
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_idle", {busy, done}, 2'b00);
    start_fill(5, 5);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        take_pair(i, j, 0, w);
        if (i == 0 && j == 0) check("t5_restart_lat", w, 2);
      end

    // Randomized contents, lengths, stalls and traceback addresses
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        mem_a[k] = 9'($urandom);
        mem_b[k] = 9'($urandom);
      end
      la = $urandom_range(0, 7);
      lb = $urandom_range(0, 7);
      ela = clampl(la);
      elb = clampl(lb);
      stall_tot = 0;
      start_fill(la, lb);
      for (int i = 0; i < ela; i++)
        for (int j = 0; j < elb; j++) begin
          st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
          stall_tot += st;
          take_pair(i, j, st, w);
        end
      check($sformatf("rnd%0d_done", r), {done, busy}, 2'b10);
      check($sformatf("rnd%0d_cyc", r), cyc - t0, 3 * ela * elb + stall_tot);
      trace_seq($urandom_range(0, N - 1), $urandom_range(0, N - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
